// File: rtl/bubble_sort_ctrl_pkg.sv
// Shared types and constants for the bubble-sort sequencer:
// the FSM state encoding and the signed word type.
package bubble_sort_ctrl_pkg;

  localparam int WORD_W = 8;

  typedef logic signed [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SORT = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/bubble_sort_ctrl_if.sv
// Producer/consumer handshake bundle for bubble_sort_ctrl, plus its status outputs.
interface bubble_sort_ctrl_if;
  import bubble_sort_ctrl_pkg::*;

  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic [7:0]        swap_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, swap_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, swap_count
  );
endinterface

// File: rtl/bubble_sort_ctrl_signed_gt8.sv
// Purely combinational signed greater-than on two 8-bit two's-complement words.
module signed_gt8
  import bubble_sort_ctrl_pkg::*;
(
  input  word_t a,
  input  word_t b,
  output logic  gt
);
  assign gt = (a > b);
endmodule

// File: rtl/bubble_sort_ctrl.sv
// Loads DEPTH signed words, sorts them ascending with an early-exit bubble sort
// (one compare per cycle through a single shared comparator), then streams them out.
module bubble_sort_ctrl
  import bubble_sort_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  bubble_sort_ctrl_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX  = idx_t'(DEPTH - 1);
  localparam idx_t LAST_PASS = idx_t'(DEPTH - 2);

  state_e     state_q, state_d;
  idx_t       wr_idx_q, wr_idx_d;
  idx_t       rd_idx_q, rd_idx_d;
  idx_t       i_q, i_d;
  idx_t       pass_q, pass_d;
  logic       swapped_q, swapped_d;
  logic [7:0] swap_cnt_q, swap_cnt_d;
  word_t      mem_q [DEPTH];
  word_t      mem_d [DEPTH];

  idx_t  i_plus1;
  idx_t  last_i;
  word_t cmp_a, cmp_b;
  logic  cmp_gt;
  logic  swap_seen;

  assign i_plus1 = i_q + idx_t'(1);
  assign last_i  = LAST_PASS - pass_q;
  assign cmp_a   = mem_q[i_q];
  assign cmp_b   = mem_q[i_plus1];

  signed_gt8 u_gt (
    .a  (cmp_a),
    .b  (cmp_b),
    .gt (cmp_gt)
  );

  // NOTE: combinational blocks use blocking '=' with every target defaulted first,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    i_d        = i_q;
    pass_d     = pass_q;
    swapped_d  = swapped_q;
    swap_cnt_d = swap_cnt_q;
    mem_d      = mem_q;
    swap_seen  = swapped_q | cmp_gt;

    unique case (state_q)
      ST_LOAD: begin
        if (bus.in_valid) begin
          mem_d[wr_idx_q] = bus.in_data;
          wr_idx_d        = wr_idx_q + idx_t'(1);
          if (wr_idx_q == '0) swap_cnt_d = '0;
          if (wr_idx_q == LAST_IDX) begin
            state_d   = ST_SORT;
            wr_idx_d  = '0;
            pass_d    = '0;
            i_d       = '0;
            swapped_d = 1'b0;
          end
        end
      end

      ST_SORT: begin
        // Equal words fail the strict compare and stay put, keeping the sort stable.
        if (cmp_gt) begin
          mem_d[i_q]     = cmp_b;
          mem_d[i_plus1] = cmp_a;
          swap_cnt_d     = swap_cnt_q + 8'd1;
        end
        if (i_q == last_i) begin
          if (!swap_seen || pass_q == LAST_PASS) begin
            state_d  = ST_OUT;
            rd_idx_d = '0;
          end else begin
            pass_d    = pass_q + idx_t'(1);
            i_d       = '0;
            swapped_d = 1'b0;
          end
        end else begin
          i_d       = i_plus1;
          swapped_d = swap_seen;
        end
      end

      ST_OUT: begin
        if (bus.out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            state_d  = ST_LOAD;
            rd_idx_d = '0;
            wr_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + idx_t'(1);
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      i_q        <= '0;
      pass_q     <= '0;
      swapped_q  <= 1'b0;
      swap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      i_q        <= i_d;
      pass_q     <= pass_d;
      swapped_q  <= swapped_d;
      swap_cnt_q <= swap_cnt_d;
    end
  end

  // NOTE: the word store is deliberately not reset; its contents are always
  // rewritten by LOAD before they are read, so a reset would only add fanout.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.in_ready   = (state_q == ST_LOAD);
  assign bus.busy       = (state_q == ST_SORT);
  assign bus.out_valid  = (state_q == ST_OUT);
  assign bus.out_data   = (state_q == ST_OUT) ? mem_q[rd_idx_q] : '0;
  assign bus.swap_count = swap_cnt_q;

endmodule
